// File: rtl/bip_pkg.sv
// Shared definitions for the program-counter run-control path.
package bip_pkg;

    localparam int PC_W = 11;

    localparam logic [1:0] ST_IDLE      = 2'd0;
    localparam logic [1:0] ST_RUN       = 2'd1;
    localparam logic [1:0] ST_STEP_WAIT = 2'd2;
    localparam logic [1:0] ST_DONE      = 2'd3;

    typedef enum logic [1:0] {
        IDLE      = ST_IDLE,
        RUN       = ST_RUN,
        STEP_WAIT = ST_STEP_WAIT,
        DONE      = ST_DONE
    } seq_state_t;

endpackage

// File: rtl/pc_sequencer_sat_counter.sv
// Saturating up-counter with synchronous clear; holds at all-ones instead of wrapping.
module sat_counter #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] count
);

    logic [W-1:0] count_reg;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count_reg <= '0;
        end else if (clr) begin
            count_reg <= '0;
        end else if (inc && (count_reg != {W{1'b1}})) begin
            count_reg <= count_reg + 1'b1;
        end
    end

    assign count = count_reg;

endmodule

// File: rtl/pc_sequencer.sv
// Run-control FSM driving the program counter: start, free-run, single-step,
// taken-branch loads, halt and wrap-around stop, plus executed-instruction count.
import bip_pkg::*;

module pc_sequencer #(
    parameter int N  = PC_W,
    parameter int CW = 32
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic          step_mode,
    input  logic          step,
    input  logic          halt_req,
    input  logic          branch,
    input  logic [N-1:0]  target,
    input  logic [N-1:0]  pc,
    output logic          cnt_clr,
    output logic          cnt_load,
    output logic          cnt_en,
    output logic          cnt_up,
    output logic [N-1:0]  cnt_d,
    output logic          running,
    output logic          done,
    output logic          wrap_err,
    output logic [CW-1:0] icount
);

    seq_state_t state_reg, state_next;
    logic       wrap_err_reg;
    logic       icount_clr, icount_inc, wrap_set;
    logic       execute;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg    <= IDLE;
            wrap_err_reg <= 1'b0;
        end else begin
            state_reg <= state_next;
            if (icount_clr) begin
                wrap_err_reg <= 1'b0;
            end else if (wrap_set) begin
                wrap_err_reg <= 1'b1;
            end
        end
    end

    assign execute = (state_reg == RUN) || ((state_reg == STEP_WAIT) && step);

    always_comb begin
        state_next = state_reg;
        cnt_clr    = 1'b0;
        cnt_load   = 1'b0;
        cnt_en     = 1'b0;
        cnt_up     = 1'b0;
        cnt_d      = target;
        icount_clr = 1'b0;
        icount_inc = 1'b0;
        wrap_set   = 1'b0;
        case (state_reg)
            IDLE, DONE: begin
                if (start) begin
                    cnt_clr    = 1'b1;
                    icount_clr = 1'b1;
                    state_next = step_mode ? STEP_WAIT : RUN;
                end
            end
            default: begin
                // RUN and STEP_WAIT share the execute decode; state is held unless we stop.
                if (execute) begin
                    if (halt_req) begin
                        icount_inc = 1'b1;
                        state_next = DONE;
                    end else if (branch) begin
                        cnt_load   = 1'b1;
                        icount_inc = 1'b1;
                    end else if (pc == {N{1'b1}}) begin
                        wrap_set   = 1'b1;
                        state_next = DONE;
                    end else begin
                        cnt_en     = 1'b1;
                        cnt_up     = 1'b1;
                        icount_inc = 1'b1;
                    end
                end
            end
        endcase
    end

    sat_counter #(.W(CW)) u_icount (
        .clk   (clk),
        .reset (reset),
        .clr   (icount_clr),
        .inc   (icount_inc),
        .count (icount)
    );

    assign running  = (state_reg == RUN) || (state_reg == STEP_WAIT);
    assign done     = (state_reg == DONE);
    assign wrap_err = wrap_err_reg;

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench: pc_sequencer closed-loop with a behavioural program counter.
module tb_pc_sequencer;

    localparam int N  = 11;
    localparam int CW = 32;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          start = 1'b0;
    logic          step_mode = 1'b0;
    logic          step = 1'b0;
    logic          halt_req, branch;
    logic [N-1:0]  target;
    logic [N-1:0]  pc;
    logic          cnt_clr, cnt_load, cnt_en, cnt_up;
    logic [N-1:0]  cnt_d;
    logic          running, done, wrap_err;
    logic [CW-1:0] icount;

    // Instruction "decode" stand-ins: halt/branch fire when pc reaches a chosen address.
    logic          halt_en = 1'b0;
    logic [N-1:0]  halt_pc = '0;
    logic          br_en = 1'b0;
    logic [N-1:0]  br_pc = '0;
    logic [N-1:0]  br_target = '0;

    int total = 0;
    int bad = 0;

    assign halt_req = halt_en && (pc == halt_pc);
    assign branch   = br_en && (pc == br_pc);
    assign target   = br_target;

    always #5 clk = ~clk;

    // Universal binary counter used as the PC.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)        pc <= '0;
        else if (cnt_clr)  pc <= '0;
        else if (cnt_load) pc <= cnt_d;
        else if (cnt_en)   pc <= cnt_up ? pc + 1'b1 : pc - 1'b1;
    end

    pc_sequencer #(.N(N), .CW(CW)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .step_mode (step_mode),
        .step      (step),
        .halt_req  (halt_req),
        .branch    (branch),
        .target    (target),
        .pc        (pc),
        .cnt_clr   (cnt_clr),
        .cnt_load  (cnt_load),
        .cnt_en    (cnt_en),
        .cnt_up    (cnt_up),
        .cnt_d     (cnt_d),
        .running   (running),
        .done      (done),
        .wrap_err  (wrap_err),
        .icount    (icount)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
        end else begin
            $display("ok   %s: 0x%0h", tag, got);
        end
    endtask

    task automatic run_start(input logic mode);
        @(negedge clk);
        start = 1'b1;
        step_mode = mode;
        @(negedge clk);
        start = 1'b0;
        step_mode = 1'b0;
    endtask

    task automatic step_pulse();
        @(negedge clk);
        step = 1'b1;
        @(negedge clk);
        step = 1'b0;
    endtask

    logic [N-1:0] seq2 [7] = '{11'h000, 11'h001, 11'h002, 11'h003, 11'h100, 11'h101, 11'h102};
    logic [N-1:0] seq4 [4] = '{11'h000, 11'h001, 11'h7FE, 11'h7FF};

    initial begin
        // Reset state
        #12;
        check("rst_running", running, 0);
        check("rst_done", done, 0);
        check("rst_icount", icount, 0);
        check("rst_cnt", {cnt_clr, cnt_load, cnt_en, cnt_up}, 4'b0000);
        @(negedge clk);
        reset = 1'b1;

        // Free-run to halt at pc=5
        halt_en = 1'b1; halt_pc = 11'd5;
        run_start(1'b0);
        check("t1_running", running, 1);
        for (int i = 0; i <= 5; i++) begin
            check($sformatf("t1_pc%0d", i), pc, i);
            @(negedge clk);
        end
        check("t1_done", done, 1);
        check("t1_pc_hold", pc, 5);
        check("t1_icount", icount, 6);
        check("t1_wrap", wrap_err, 0);

        // Branch to 0x100 at pc=3, halt at 0x102
        halt_pc = 11'h102;
        br_en = 1'b1; br_pc = 11'd3; br_target = 11'h100;
        run_start(1'b0);
        for (int i = 0; i < 7; i++) begin
            check($sformatf("t2_pc%0d", i), pc, seq2[i]);
            @(negedge clk);
        end
        check("t2_done", done, 1);
        check("t2_icount", icount, 7);

        // Single-step: three pulses four cycles apart
        halt_en = 1'b0; br_en = 1'b0;
        run_start(1'b1);
        for (int s = 0; s < 3; s++) begin
            repeat (3) @(negedge clk);
            check($sformatf("t3_hold%0d", s), pc, s);
            step_pulse();
            check($sformatf("t3_pc%0d", s + 1), pc, s + 1);
        end
        repeat (2) @(negedge clk);
        check("t3_pc_final", pc, 3);
        check("t3_running", running, 1);
        check("t3_done", done, 0);
        check("t3_icount", icount, 3);

        // Leave step mode via reset
        reset = 1'b0;
        #1;
        check("t3_rst_running", running, 0);
        @(negedge clk);
        reset = 1'b1;

        // Branch to 0x7FE and wrap
        br_en = 1'b1; br_pc = 11'd1; br_target = 11'h7FE;
        run_start(1'b0);
        for (int i = 0; i < 4; i++) begin
            check($sformatf("t4_pc%0d", i), pc, seq4[i]);
            @(negedge clk);
        end
        check("t4_wrap", wrap_err, 1);
        check("t4_done", done, 1);
        check("t4_pc", pc, 11'h7FF);
        check("t4_icount", icount, 3);
        repeat (2) @(negedge clk);
        check("t4_wrap_hold", wrap_err, 1);
        check("t4_pc_hold", pc, 11'h7FF);

        // Halt+branch at pc=2; start during RUN ignored
        halt_en = 1'b1; halt_pc = 11'd2;
        br_en = 1'b1; br_pc = 11'd2; br_target = 11'h055;
        run_start(1'b0);
        check("t5_wrap_clr", wrap_err, 0);
        @(negedge clk);
        start = 1'b1; step_mode = 1'b1;
        @(negedge clk);
        start = 1'b0; step_mode = 1'b0;
        check("t5_pc_no_restart", pc, 2);
        @(negedge clk);
        check("t5_done", done, 1);
        check("t5_pc", pc, 2);
        check("t5_icount", icount, 3);

        // Reset mid-run at pc=9
        halt_en = 1'b0; br_en = 1'b0;
        run_start(1'b0);
        repeat (9) @(negedge clk);
        check("t6_pc9", pc, 9);
        reset = 1'b0;
        #1;
        check("t6_running", running, 0);
        check("t6_icount", icount, 0);
        check("t6_cnt", {cnt_clr, cnt_load, cnt_en, cnt_up}, 4'b0000);
        @(negedge clk);
        reset = 1'b1;
        run_start(1'b0);
        check("t6_restart_pc", pc, 0);
        @(negedge clk);
        check("t6_restart_pc1", pc, 1);
        check("t6_restart_icount", icount, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/pc_sequencer.md
# pc_sequencer

Run-control FSM that sits directly upstream of the program-counter instance of the universal binary counter and drives its syn_clr/load/en/up/d inputs. It starts, free-runs or single-steps program execution, applies taken-branch loads, stops on a decoded halt instruction or on PC wrap-around, and keeps a saturating executed-instruction count for the debug/UART reporting path.

## Interface
- N, 11: PC width; must match the counter's N.
- CW, 32: width of the executed-instruction counter.
- clk  in  1  system clock, all state updates on rising edge.
- reset  in  1  asynchronous, active-low reset.
- start  in  1  single-cycle pulse; begins a program run from PC 0.
- step_mode  in  1  1 = single-step, 0 = free-run; sampled only on the cycle start is accepted.
- step  in  1  single-cycle pulse; executes one instruction in single-step mode.
- halt_req  in  1  current instruction decodes as HALT.
- branch  in  1  current instruction is a taken branch.
- target  in  N  branch destination address.
- pc  in  N  counter q (current PC).
- cnt_clr, cnt_load, cnt_en, cnt_up  out  1 each  to counter syn_clr/load/en/up.
- cnt_d  out  N  to counter d.
- running  out  1  state is RUN or STEP_WAIT.
- done  out  1  state is DONE.
- wrap_err  out  1  run ended because PC would wrap past 2^N-1.
- icount  out  CW  executed-instruction count, saturating.

## Operation
- States: IDLE, RUN, STEP_WAIT, DONE.
- cnt_* outputs are combinational (Mealy) from state and inputs; counter commits them at the same edge the FSM changes state. Default: all cnt_* = 0, cnt_d = target.
- IDLE / DONE: on start=1 -> cnt_clr=1, icount<=0, wrap_err<=0, next = step_mode ? STEP_WAIT : RUN. Other inputs ignored.
- Execute cycle (every RUN cycle; a STEP_WAIT cycle with step=1), priority order:
  - halt_req=1 -> no PC change, icount+1, next DONE.
  - branch=1 -> cnt_load=1, cnt_d=target, icount+1, stay.
  - pc = 2^N-1 -> no PC change, wrap_err<=1, next DONE, icount unchanged.
  - else -> cnt_en=1, cnt_up=1, icount+1, stay.
- STEP_WAIT with step=0: all cnt_* = 0, nothing changes.
- After a STEP_WAIT execute cycle, return to STEP_WAIT unless DONE selected.
- cnt_up is never 0 while cnt_en=1; decrement path of the counter is unused.
- icount saturates at 2^CW-1; never wraps.
- start ignored in RUN and STEP_WAIT; step ignored outside STEP_WAIT.
- halt_req and branch together: halt wins. Branch at pc=2^N-1 is legal (load, no wrap_err).

## Timing
- Reset (reset=0, async): state IDLE, running=0, done=0, wrap_err=0, icount=0; cnt_* decode to 0 immediately. Reset mid-run abandons the run; counter has its own reset, top level inverts reset for it.
- start accepted at edge k: pc=0 and running=1 after edge k; first instruction executes in cycle k+1.
- Free-run: one PC update per clock, zero bubbles.
- Halt at cycle h: done=1 after edge h, pc unchanged (points at HALT).
- wrap_err and done rise on the same edge; both hold until next accepted start or reset.

## Structure
- Shared package bip_pkg: state encoding localparams (IDLE=2'd0, RUN=2'd1, STEP_WAIT=2'd2, DONE=2'd3) and default PC width 11.
- One sub-module: sat_counter (width CW, clr, inc, saturating) for icount.
- FSM register, next-state decode and cnt_* decode stay in pc_sequencer.

## Test plan
- Reset then start, step_mode=0, halt_req asserted when pc=5 -> pc sequence 0..5, done=1, icount=6, wrap_err=0.
- Free-run, branch=1 target=0x100 when pc=3, halt at pc=0x102 -> pc 0,1,2,3,0x100,0x101,0x102; icount=7.
- step_mode=1, three step pulses 4 cycles apart -> pc advances exactly 0->1->2->3, held between pulses; running=1, done=0.
- Branch to 0x7FE, no halt -> pc 0x7FE, 0x7FF, then wrap_err=1, done=1, pc stays 0x7FF.
- halt_req and branch both high at pc=2 -> no load, done=1, pc=2; start asserted during RUN earlier -> ignored.
- reset driven low mid-run at pc=9 -> running=0, icount=0 immediately; subsequent start restarts from pc 0.
